// File: rtl/controle_iluminacao.sv
// controle_iluminacao: lamp sequencer with debounced button, short/long press and auto-shutdown
module controle_iluminacao #(
  parameter int DEBOUNCE_T      = 4,
  parameter int LONG_PRESS_T    = 20,
  parameter int AUTO_SHUTDOWN_T = 10,
  parameter int WARN_T          = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  input  logic infravermelho,
  output logic L,
  output logic auto_mode,
  output logic aviso
);
  localparam int MAXP = (DEBOUNCE_T > LONG_PRESS_T) ?
                        ((DEBOUNCE_T > AUTO_SHUTDOWN_T) ? DEBOUNCE_T : AUTO_SHUTDOWN_T) :
                        ((LONG_PRESS_T > AUTO_SHUTDOWN_T) ? LONG_PRESS_T : AUTO_SHUTDOWN_T);
  localparam int W = $clog2(MAXP) + 1;
  localparam logic [W-1:0] DB_LAST = W'(DEBOUNCE_T - 1);
  localparam logic [W-1:0] LP_MAX  = W'(LONG_PRESS_T);
  localparam logic [W-1:0] LP_LAST = W'(LONG_PRESS_T - 1);
  localparam logic [W-1:0] AS_LAST = W'(AUTO_SHUTDOWN_T - 1);
  localparam logic [W-1:0] AS_WARN = W'(AUTO_SHUTDOWN_T - WARN_T);

  typedef enum logic [1:0] {DESLIGADA, LIGADA, CONTAGEM} estado_t;

  logic s1_q, s2_q, db_q, db_d, db_dly_q;
  logic long_q, long_d, short_q, short_d, fired_q, fired_d;
  logic auto_q, auto_d, inh_q, inh_d, l_q, l_d, aviso_q, aviso_d;
  logic [W-1:0] db_cnt_q, db_cnt_d, press_cnt_q, press_cnt_d, timer_q, timer_d;
  estado_t state_q, state_d;

  // Debounce, press length measurement and press classification
  always_comb begin
    db_cnt_d    = (s2_q != db_q && db_cnt_q != DB_LAST) ? db_cnt_q + 1'b1 : '0;
    db_d        = (s2_q != db_q && db_cnt_q == DB_LAST) ? s2_q : db_q;
    press_cnt_d = !db_q ? '0 : (press_cnt_q == LP_MAX) ? press_cnt_q : press_cnt_q + 1'b1;
    long_d      = db_q && press_cnt_q == LP_LAST;
    fired_d     = long_d ? 1'b1 : (db_q && !db_dly_q) ? 1'b0 : fired_q;
    short_d     = db_dly_q && !db_q && !fired_q;
    auto_d      = auto_q ^ long_q;
  end

  // Button path registers: synchroniser, debouncer, press pulses, auto mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      db_q        <= 1'b0;
      db_dly_q    <= 1'b0;
      db_cnt_q    <= '0;
      press_cnt_q <= '0;
      long_q      <= 1'b0;
      short_q     <= 1'b0;
      fired_q     <= 1'b0;
      auto_q      <= 1'b0;
    end else begin
      s1_q        <= botao;
      s2_q        <= s1_q;
      db_q        <= db_d;
      db_dly_q    <= db_q;
      db_cnt_q    <= db_cnt_d;
      press_cnt_q <= press_cnt_d;
      long_q      <= long_d;
      short_q     <= short_d;
      fired_q     <= fired_d;
      auto_q      <= auto_d;
    end
  end

  // Lamp state machine, countdown timer, inhibit after manual switch-off
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      DESLIGADA: if (short_q || (auto_q && infravermelho && !inh_q)) state_d = LIGADA;
      LIGADA:
        if (short_q) state_d = DESLIGADA;
        else if (auto_q && !infravermelho) begin
          state_d = CONTAGEM;
          timer_d = '0;
        end
      CONTAGEM:
        if (short_q) state_d = DESLIGADA;
        else if (infravermelho || !auto_q) state_d = LIGADA;
        else if (timer_q == AS_LAST) state_d = DESLIGADA;
        else timer_d = timer_q + 1'b1;
      default: state_d = DESLIGADA;
    endcase
    inh_d   = (short_q && (state_q == LIGADA || state_q == CONTAGEM) && infravermelho) ? 1'b1 :
              (infravermelho ? inh_q : 1'b0);
    l_d     = state_d != DESLIGADA;
    aviso_d = state_d == CONTAGEM && timer_d >= AS_WARN;
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DESLIGADA;
      timer_q <= '0;
      inh_q   <= 1'b0;
      l_q     <= 1'b0;
      aviso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      inh_q   <= inh_d;
      l_q     <= l_d;
      aviso_q <= aviso_d;
    end
  end

  assign L         = l_q;
  assign auto_mode = auto_q;
  assign aviso     = aviso_q;
endmodule

// File: tb/tb_controle_iluminacao.sv
// tb_controle_iluminacao: table, directed and randomized checks of the lighting sequencer
module tb_controle_iluminacao;
  localparam int D = 4, LP = 20, AST = 10, WN = 3, NR = 3000;

  logic clk = 1'b0, rst = 1'b0, botao = 1'b0, infravermelho = 1'b0;
  logic L, auto_mode, aviso;
  int ncmp = 0, nerr = 0;

  controle_iluminacao #(.DEBOUNCE_T(D), .LONG_PRESS_T(LP), .AUTO_SHUTDOWN_T(AST), .WARN_T(WN)) dut (
    .clk(clk), .rst(rst), .botao(botao), .infravermelho(infravermelho),
    .L(L), .auto_mode(auto_mode), .aviso(aviso)
  );

  always #5 clk = ~clk;

  typedef struct {int hold; bit l; bit am;} vec_t;
  vec_t tbl[8];

  bit btn[NR];
  bit irv[NR];
  bit sp_at[NR + 100];
  bit tg_at[NR + 100];

  task automatic chk(input string nm, input logic got, input logic exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_L", L, 1'b0);
    chk("rst_auto", auto_mode, 1'b0);
    chk("rst_aviso", aviso, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int h);
    botao = 1'b1;
    step(h);
    botao = 1'b0;
  endtask

  task automatic countdown();
    for (int k = 0; k < AST; k++) begin
      chk("cd_L", L, 1'b1);
      chk("cd_aviso", aviso, k >= AST - WN);
      step(1);
    end
    chk("cd_end_L", L, 1'b0);
    chk("cd_end_aviso", aviso, 1'b0);
  endtask

  initial begin
    bit on, inh, am, ni, ir;
    int cnt, c, h;
    tbl[0] = '{10, 1, 0};
    tbl[1] = '{10, 0, 0};
    tbl[2] = '{3,  0, 0};
    tbl[3] = '{4,  1, 0};
    tbl[4] = '{19, 0, 0};
    tbl[5] = '{20, 0, 1};
    tbl[6] = '{30, 0, 0};
    tbl[7] = '{1,  0, 0};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press(tbl[i].hold);
      step(D + LP + 20);
      chk($sformatf("tbl%0d_L", i), L, tbl[i].l);
      chk($sformatf("tbl%0d_auto", i), auto_mode, tbl[i].am);
    end

    do_reset();
    press(10);
    step(D + 3);
    chk("t1_before", L, 1'b0);
    step(1);
    chk("t1_edge", L, 1'b1);
    chk("t1_auto", auto_mode, 1'b0);
    press(10);
    step(D + 4);
    chk("t1_off", L, 1'b0);

    botao = 1'b1; step(1);
    botao = 1'b0; step(1);
    press(11);
    step(30);
    chk("t2_bouncy", L, 1'b1);

    do_reset();
    press(30);
    step(D + 30);
    chk("t3_auto", auto_mode, 1'b1);
    chk("t3_L", L, 1'b0);

    infravermelho = 1'b1; step(1);
    chk("t4_on", L, 1'b1);
    infravermelho = 1'b0; step(1);
    countdown();

    infravermelho = 1'b1; step(1);
    infravermelho = 1'b0; step(1);
    step(5);
    infravermelho = 1'b1; step(1);
    chk("t5_L", L, 1'b1);
    chk("t5_aviso", aviso, 1'b0);
    infravermelho = 1'b0; step(1);
    countdown();

    infravermelho = 1'b1; step(1);
    chk("t6_on", L, 1'b1);
    press(10);
    step(D + 4);
    chk("t6_off", L, 1'b0);
    step(5);
    chk("t6_inhibit", L, 1'b0);
    infravermelho = 1'b0; step(1);
    chk("t6_clear", L, 1'b0);
    infravermelho = 1'b1; step(1);
    chk("t6_relight", L, 1'b1);
    infravermelho = 1'b0; step(9);
    chk("t6_aviso_pre", aviso, 1'b1);
    do_reset();

    c = 5;
    ir = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if ($urandom_range(0, 9) == 0) ir = ~ir;
      irv[i] = ir;
    end
    while (c < NR - 80) begin
      h = $urandom_range(0, 1) ? $urandom_range(2, 19) : $urandom_range(20, 28);
      for (int i = c; i < c + h; i++) btn[i] = 1'b1;
      if (h >= LP) tg_at[c + D + LP + 2] = 1'b1;
      else if (h >= D) sp_at[c + h + D + 3] = 1'b1;
      c += h + $urandom_range(D + 6, 40);
    end
    on = 0; inh = 0; am = 0; cnt = -1;
    for (int cyc = 0; cyc < NR; cyc++) begin
      botao = btn[cyc];
      infravermelho = irv[cyc];
      @(posedge clk);
      ni = (sp_at[cyc] && on && irv[cyc]) ? 1'b1 : (irv[cyc] ? inh : 1'b0);
      if (sp_at[cyc]) begin on = !on; cnt = -1; end
      else if (!on) on = am && irv[cyc] && !inh;
      else if (cnt < 0) cnt = (am && !irv[cyc]) ? 0 : -1;
      else if (irv[cyc] || !am) cnt = -1;
      else if (cnt == AST - 1) begin on = 0; cnt = -1; end
      else cnt++;
      inh = ni;
      am ^= tg_at[cyc];
      @(negedge clk);
      chk("rnd_L", L, on);
      chk("rnd_auto", auto_mode, am);
      chk("rnd_aviso", aviso, on && cnt >= AST - WN);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
